bsg_fma_norm_round: RTL
=======================

# bsg_fma_norm_round

Two-stage pipelined normalize-and-round stage placed directly downstream of the FMA datapath core. It consumes the core's 48-bit unsigned result magnitude plus sign, biased exponent and sticky side-band, and produces a packed IEEE-754 single-precision word with exception flags. Valid/ready handshakes sit on both sides, and the block sustains one result per cycle.

## Interface
- `round_en_p`, default 1: 1 = round-to-nearest-even; 0 = truncate toward zero.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset. **Asynchronous, active-high.**
- `v_i`  in  1  input valid.
- `ready_o`  out  1  input ready; a transfer occurs when `v_i & ready_o`.
- `mant_i`  in  48  unsigned magnitude; binary point between bits 46 and 45 (2.46 format).
- `exp_i`  in  10  signed two's-complement biased exponent (bias 127) of the value `mant_i` × 2^0 in 2.46 format.
- `sign_i`  in  1  result sign.
- `sticky_i`  in  1  OR of magnitude bits already discarded upstream.
- `v_o`  out  1  output valid.
- `ready_i`  in  1  downstream ready; a transfer occurs when `v_o & ready_i`.
- `res_o`  out  32  packed fp32 result.
- `flags_o`  out  3  {overflow, underflow, inexact}.

## Operation
- Stage 1 (normalize), on accept:
  - `lz` = leading-zero count of `mant_i`.
  - `m_n` = `mant_i << lz`.
  - `e_n` = `exp_i + 1 - lz`, computed at 11 bits signed.
  - Zero flag = (`mant_i == 0`).
- Stage 2 (round/pack):
  - `frac` = `m_n[47:24]`; guard = `m_n[23]`; sticky = `|m_n[22:0] | sticky_i`.
  - Round up when `round_en_p & guard & (sticky | frac[0])`.
  - If the 24-bit increment carries out: `frac` = 24'h800000, `e_n` + 1.
  - inexact = `guard | sticky`.
- Special cases, in priority order:
  - zero → `{sign,31'b0}`, flags 0.
  - `e` ≥ 255 → `{sign,8'hFF,23'b0}`, overflow=1, inexact=1.
  - `e` ≤ 0 → `{sign,31'b0}` (flush, no subnormals), underflow=1, inexact=1.
  - otherwise → `{sign, e[7:0], frac[22:0]}`.
- Pipeline control: each stage holds one valid bit plus payload.
  - Stage 2 advances when `~v_o | ready_i`.
  - Stage 1 advances when `~s1_v | s2_advance`.
  - `ready_o = ~s1_v | s2_advance`; no combinational path from `v_i` to `ready_o`.
- Stalled stages hold their payload. `res_o` and `flags_o` are stable while `v_o & ~ready_i`.

## Timing
- Latency: 2 cycles, from the accepting edge to `v_o` high, with no stall.
- Throughput: 1 result/cycle with `ready_i` held high.
- Reset (async assert) clears both valid bits and sets `res_o`=0, `flags_o`=0, `v_o`=0.
- `ready_o` = 1 after reset.
- Reset mid-operation: in-flight items are discarded and no partial output appears.
- Both stages full and `ready_i`=0: `ready_o`=0.
- Both stages full and `ready_i` rises: in the same cycle, output pops, stage 1 moves, and a new input is accepted (no bubble).
- A simultaneous accept and pop on the same edge is legal in all occupancy states.

## Structure
- Shared package `bsg_fma_pkg` holds:
  - fp32 struct {sign, exp[7:0], frac[22:0]};
  - flags struct {overflow, underflow, inexact};
  - constants: bias 127, exp width 10, mantissa width 48, inf exponent 8'hFF.
- Sub-module `bsg_fma_lzc48`: combinational 48-bit leading-zero counter.
  - Output 6 bits; returns 48 for zero input.
  - Reused by the future alignment stage.

## Test plan
- 1.0: `mant_i`=48'h4000_0000_0000, `exp_i`=127, sign 0 → `res_o`=32'h3F80_0000, flags 0, `v_o` exactly 2 cycles after accept.
- Round carry: `mant_i`=48'h7FFF_FFC0_0000, `exp_i`=127 → 32'h4000_0000, inexact=1.
- Ties:
  - 48'h4000_0040_0000 → 32'h3F80_0000, inexact=1 (tie to even).
  - 48'h4000_00C0_0000 → 32'h3F80_0002.
  - With `round_en_p`=0, the second case → 32'h3F80_0001.
- Range:
  - `exp_i`=300 → 32'h7F80_0000, overflow=1.
  - `exp_i`=0 with 1.0 mantissa, sign 1 → 32'h8000_0000, underflow=1.
  - `mant_i`=0 → signed zero, flags 0.
- Backpressure: stream 8 back-to-back inputs with `ready_i` low for cycles 3–5.
  - `ready_o` drops once both stages fill.
  - Outputs stay stable while stalled.
  - All 8 results emerge in order, none lost or duplicated.
- Reset: assert `reset_i` asynchronously with 2 items in flight → `v_o`=0 immediately, `ready_o`=1, no stale result after release.

Source files
------------

// File: rtl/bsg_fma_pkg.sv
// Shared types and constants for the FMA datapath blocks.
// Covers the fp32 result layout, the exception flag bundle and the datapath widths.
package bsg_fma_pkg;

    localparam int unsigned FMA_BIAS     = 127;
    localparam int unsigned FMA_EXP_W    = 10;
    localparam int unsigned FMA_MANT_W   = 48;
    localparam logic [7:0]  FP32_INF_EXP = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fma_flags_t;

endpackage

// File: rtl/bsg_fma_lzc48.sv
// Combinational 48-bit leading-zero counter; an all-zero input yields 48.
// Each byte is counted on its own, then the first non-zero byte from the top wins.
module bsg_fma_lzc48 (
    input  logic [47:0] a_i,
    output logic [5:0]  lz_o
);

    logic [5:0]  grp_nz;
    logic [17:0] grp_lz;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_byte
            logic [7:0] byte_w;
            logic [2:0] lz_w;

            assign byte_w = a_i[47-8*gi -: 8];

            always_comb begin
                lz_w = 3'd7;
                for (int b = 0; b < 8; b++) begin
                    if (byte_w[b]) begin
                        lz_w = 3'(7 - b);
                    end
                end
            end

            assign grp_nz[gi]         = |byte_w;
            assign grp_lz[3*gi +: 3]  = lz_w;
        end
    endgenerate

    // Group 0 is the most significant byte, so walking downward lets it win last.
    always_comb begin
        lz_o = 6'd48;
        for (int g = 5; g >= 0; g--) begin
            if (grp_nz[g]) begin
                lz_o = 6'(8 * g) + {3'b000, grp_lz[3*g +: 3]};
            end
        end
    end

endmodule

// File: rtl/bsg_fma_norm_round.sv
// Two-stage normalize / round-and-pack stage behind the FMA core.
// Stage 1 left-justifies the magnitude; stage 2 rounds, handles specials and packs fp32.
module bsg_fma_norm_round
    import bsg_fma_pkg::*;
#(
    parameter bit round_en_p = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    output logic                  ready_o,
    input  logic [FMA_MANT_W-1:0] mant_i,
    input  logic [FMA_EXP_W-1:0]  exp_i,
    input  logic                  sign_i,
    input  logic                  sticky_i,
    output logic                  v_o,
    input  logic                  ready_i,
    output logic [31:0]           res_o,
    output logic [2:0]            flags_o
);

    // Stage 1 state
    logic               s1_v_q, s1_v_d;
    logic [47:0]        s1_mant_q, s1_mant_d;
    logic signed [10:0] s1_exp_q, s1_exp_d;
    logic               s1_sign_q, s1_sign_d;
    logic               s1_sticky_q, s1_sticky_d;
    logic               s1_zero_q, s1_zero_d;

    // Stage 2 state
    logic       v_o_q, v_o_d;
    fp32_t      res_q, res_d;
    fma_flags_t flags_q, flags_d;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv  = ~v_o_q | ready_i;
    assign s1_adv  = ~s1_v_q | s2_adv;
    assign ready_o = s1_adv;

    // ---------------- stage 1: normalize ----------------
    logic [5:0]         lz;
    logic [47:0]        mant_n;
    logic signed [10:0] exp_ext;
    logic signed [10:0] lz_ext;
    logic signed [10:0] exp_n;

    bsg_fma_lzc48 u_lzc (
        .a_i  (mant_i),
        .lz_o (lz)
    );

    assign mant_n  = mant_i << lz;
    assign exp_ext = {exp_i[9], exp_i};
    assign lz_ext  = {5'b00000, lz};
    assign exp_n   = exp_ext + 11'sd1 - lz_ext;

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_mant_d   = s1_mant_q;
        s1_exp_d    = s1_exp_q;
        s1_sign_d   = s1_sign_q;
        s1_sticky_d = s1_sticky_q;
        s1_zero_d   = s1_zero_q;
        if (s1_adv) begin
            s1_v_d = v_i;
            if (v_i) begin
                s1_mant_d   = mant_n;
                s1_exp_d    = exp_n;
                s1_sign_d   = sign_i;
                s1_sticky_d = sticky_i;
                s1_zero_d   = (mant_i == '0);
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic [23:0]        frac;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic               carry;
    logic [22:0]        frac_r;
    logic signed [10:0] exp_r;
    logic               inexact;
    fp32_t              pack_res;
    fma_flags_t         pack_flags;

    always_comb begin
        frac     = s1_mant_q[47:24];
        guard    = s1_mant_q[23];
        sticky   = (|s1_mant_q[22:0]) | s1_sticky_q;
        round_up = round_en_p && guard && (sticky || frac[0]);
        // An all-ones significand that rounds up wraps to 1.0 and bumps the exponent.
        carry    = round_up && (&frac);
        frac_r   = frac[22:0] + {22'b0, round_up};
        exp_r    = carry ? (s1_exp_q + 11'sd1) : s1_exp_q;
        inexact  = guard | sticky;

        pack_res      = '0;
        pack_flags    = '0;
        pack_res.sign = s1_sign_q;
        if (s1_zero_q) begin
            pack_flags = '0;
        end else if (exp_r >= 11'sd255) begin
            pack_res.exp         = FP32_INF_EXP;
            pack_flags.overflow  = 1'b1;
            pack_flags.inexact   = 1'b1;
        end else if (exp_r <= 11'sd0) begin
            pack_flags.underflow = 1'b1;
            pack_flags.inexact   = 1'b1;
        end else begin
            pack_res.exp       = exp_r[7:0];
            pack_res.frac      = frac_r;
            pack_flags.inexact = inexact;
        end
    end

    always_comb begin
        v_o_d   = v_o_q;
        res_d   = res_q;
        flags_d = flags_q;
        if (s2_adv) begin
            v_o_d = s1_v_q;
            if (s1_v_q) begin
                res_d   = pack_res;
                flags_d = pack_flags;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_v_q      <= 1'b0;
            s1_mant_q   <= '0;
            s1_exp_q    <= '0;
            s1_sign_q   <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_zero_q   <= 1'b0;
            v_o_q       <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_mant_q   <= s1_mant_d;
            s1_exp_q    <= s1_exp_d;
            s1_sign_q   <= s1_sign_d;
            s1_sticky_q <= s1_sticky_d;
            s1_zero_q   <= s1_zero_d;
            v_o_q       <= v_o_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
        end
    end

    assign v_o     = v_o_q;
    assign res_o   = res_q;
    assign flags_o = flags_q;

endmodule
